// File: rtl/wb_arbiter_pkg.sv
// Shared core definitions: register-index width and the hard-wired zero register.
package wb_arbiter_pkg;
  localparam int unsigned RegIdxW = 5;
  typedef logic [RegIdxW-1:0] reg_idx_t;
  localparam reg_idx_t RegX0 = '0;
endpackage

// File: rtl/wb_load_fifo.sv
// Circular load-return queue; also exposes per-slot tags and valid flags so the
// owner can compare destinations of everything still waiting.
module wb_load_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 37,
  parameter int unsigned TagW  = 5,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [Width-1:0]           i_data,
  input  logic                       i_pop,
  output logic [Width-1:0]           o_head,
  output logic [CntW-1:0]            o_count,
  output logic [Depth-1:0][TagW-1:0] o_tags,
  output logic [Depth-1:0]           o_valid
);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_head;
  logic [PtrW-1:0]  r_tail;
  logic [CntW-1:0]  r_count;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= ptr_inc(r_tail);
      if (i_pop)  r_head <= ptr_inc(r_head);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_tail] <= i_data;
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

  // A slot is live when its distance from the head, modulo Depth, is below the count.
  always_comb begin
    o_valid = '0;
    o_tags  = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      o_valid[i] = ((i + Depth - 32'(r_head)) % Depth) < 32'(r_count);
      o_tags[i]  = r_mem[i][Width-1 -: TagW];
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: fixed-latency ALU results take priority over queued load
// returns for the single register-file write port; flags source hazards on queued loads.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 alu_valid_i,
  input  logic [RegIdxW-1:0]   alu_rd_i,
  input  logic [DataWidth-1:0] alu_data_i,
  input  logic                 ld_valid_i,
  output logic                 ld_ready_o,
  input  logic [RegIdxW-1:0]   ld_rd_i,
  input  logic [DataWidth-1:0] ld_data_i,
  output logic                 wb_en_o,
  output logic [RegIdxW-1:0]   wb_rd_o,
  output logic [DataWidth-1:0] wb_data_o,
  input  logic [RegIdxW-1:0]   rs1_i,
  input  logic [RegIdxW-1:0]   rs2_i,
  output logic                 hazard_o,
  output logic                 busy_o
);

  localparam int unsigned EntryW = DataWidth + RegIdxW;
  localparam int unsigned CntW   = $clog2(Depth + 1);

  logic [EntryW-1:0]                 w_head;
  logic [CntW-1:0]                   w_count;
  logic [Depth-1:0][RegIdxW-1:0]     w_tags;
  logic [Depth-1:0]                  w_valid;
  logic                              w_push;
  logic                              w_pop;
  logic                              w_alu_win;
  logic                              w_hazard;
  logic                              r_wb_en;
  logic [RegIdxW-1:0]                r_wb_rd;
  logic [DataWidth-1:0]              r_wb_data;

  assign ld_ready_o = rst_n_i & (w_count < CntW'(Depth));
  assign busy_o     = rst_n_i & (w_count != '0);

  // Loads to x0 complete the handshake but never occupy a slot.
  assign w_push    = ld_valid_i & ld_ready_o & (ld_rd_i != RegX0);
  assign w_alu_win = alu_valid_i & (alu_rd_i != RegX0);
  assign w_pop     = rst_n_i & ~w_alu_win & (w_count != '0);

  wb_load_fifo #(
    .Depth (Depth),
    .Width (EntryW),
    .TagW  (RegIdxW)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_push  (w_push),
    .i_data  ({ld_rd_i, ld_data_i}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_tags  (w_tags),
    .o_valid (w_valid)
  );

  // Only registered slots are compared, so a same-cycle enqueue is invisible
  // while a same-cycle dequeue still counts.
  always_comb begin
    w_hazard = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (w_valid[i] && (w_tags[i] != RegX0) &&
          ((w_tags[i] == rs1_i) || (w_tags[i] == rs2_i))) begin
        w_hazard = 1'b1;
      end
    end
  end

  assign hazard_o = rst_n_i & w_hazard;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_wb_en   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb_en <= w_alu_win | w_pop;
      if (w_alu_win) begin
        r_wb_rd   <= alu_rd_i;
        r_wb_data <= alu_data_i;
      end else if (w_pop) begin
        r_wb_rd   <= w_head[EntryW-1 -: RegIdxW];
        r_wb_data <= w_head[DataWidth-1:0];
      end
    end
  end

  assign wb_en_o   = r_wb_en;
  assign wb_rd_o   = r_wb_rd;
  assign wb_data_o = r_wb_data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a random phase,
// with a reference model feeding a scoreboard of expected write-port values.
module tb_wb_arbiter;

  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk;
  logic          rst_n;
  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [DW-1:0] alu_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [4:0]    ld_rd;
  logic [DW-1:0] ld_data;
  logic          wb_en;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_data;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic          hazard;
  logic          busy;

  wb_arbiter #(.DataWidth(DW), .Depth(DEPTH)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .alu_valid_i (alu_valid),
    .alu_rd_i    (alu_rd),
    .alu_data_i  (alu_data),
    .ld_valid_i  (ld_valid),
    .ld_ready_o  (ld_ready),
    .ld_rd_i     (ld_rd),
    .ld_data_i   (ld_data),
    .wb_en_o     (wb_en),
    .wb_rd_o     (wb_rd),
    .wb_data_o   (wb_data),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .hazard_o    (hazard),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  typedef struct packed {logic en; logic [4:0] rd; logic [DW-1:0] data;} wb_t;
  typedef struct packed {logic [4:0] rd; logic [DW-1:0] data;} ent_t;

  wb_t           sb[$];
  ent_t          mq[$];
  logic [4:0]    m_rd   = '0;
  logic [DW-1:0] m_data = '0;
  bit            started = 0;
  logic          m_win, m_pop, m_acc;
  wb_t           m_e, mon_e;
  ent_t          m_h;

  function automatic logic model_hazard();
    logic h = 1'b0;
    foreach (mq[i]) if (mq[i].rd != 0 && (mq[i].rd == rs1 || mq[i].rd == rs2)) h = 1'b1;
    return h & rst_n;
  endfunction

  // Reference model: evaluates each rising edge from the inputs held stable since
  // the previous edge, and queues what the write port should show afterwards.
  always @(posedge clk) begin
    started = 1;
    m_e.en  = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_rd   = '0;
      m_data = '0;
    end else begin
      m_acc = ld_valid && (mq.size() < DEPTH);
      m_win = alu_valid && (alu_rd != 0);
      m_pop = !m_win && (mq.size() != 0);
      m_e.en = m_win || m_pop;
      if (m_win) begin
        m_rd   = alu_rd;
        m_data = alu_data;
      end else if (m_pop) begin
        m_h    = mq.pop_front();
        m_rd   = m_h.rd;
        m_data = m_h.data;
      end
      if (m_acc && ld_rd != 0) mq.push_back('{ld_rd, ld_data});
    end
    m_e.rd   = m_rd;
    m_e.data = m_data;
    sb.push_back(m_e);
  end

  always @(negedge clk) begin
    if (started) begin
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("sb_wb_en", 64'(wb_en), 64'(mon_e.en));
        check("sb_wb_rd", 64'(wb_rd), 64'(mon_e.rd));
        check("sb_wb_data", 64'(wb_data), 64'(mon_e.data));
      end
      check("sb_ready", 64'(ld_ready), 64'(rst_n && mq.size() < DEPTH));
      check("sb_busy", 64'(busy), 64'(rst_n && mq.size() != 0));
      check("sb_hazard", 64'(hazard), 64'(model_hazard()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_expect(input string tag, input logic en, input logic [4:0] rd, input logic [DW-1:0] d);
    check({tag, "_en"}, 64'(wb_en), 64'(en));
    if (en) begin
      check({tag, "_rd"}, 64'(wb_rd), 64'(rd));
      check({tag, "_data"}, 64'(wb_data), 64'(d));
    end
  endtask

  initial begin
    rst_n = 0; alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_valid = 1; ld_rd = 5'd9; ld_data = 32'h99; rs1 = '0; rs2 = '0;

    // reset held with loads offered
    repeat (3) begin
      tick();
      check("rst_wb_en", 64'(wb_en), 64'd0);
      check("rst_ready", 64'(ld_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
    end
    check("rst_wb_rd", 64'(wb_rd), 64'd0);
    check("rst_wb_data", 64'(wb_data), 64'd0);
    rst_n = 1; ld_valid = 0;
    tick();
    check("rel_ready", 64'(ld_ready), 64'd1);

    // priority
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h11;
    ld_valid = 1; ld_rd = 5'd6; ld_data = 32'h22;
    tick();
    wb_expect("prio1", 1, 5'd5, 32'h11);
    alu_valid = 0; ld_valid = 0;
    tick();
    wb_expect("prio2", 1, 5'd6, 32'h22);
    tick();
    check("prio_idle_en", 64'(wb_en), 64'd0);
    check("prio_hold_rd", 64'(wb_rd), 64'd6);
    check("prio_hold_data", 64'(wb_data), 64'h22);

    // full queue while ALU owns the port
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'hA1;
    ld_valid = 1; ld_rd = 5'd10; ld_data = 32'h100;
    tick();
    ld_rd = 5'd11; ld_data = 32'h101;
    check("full_ready1", 64'(ld_ready), 64'd1);
    tick();
    check("full_ready0", 64'(ld_ready), 64'd0);
    check("full_busy", 64'(busy), 64'd1);
    ld_rd = 5'd12; ld_data = 32'h102;
    tick();
    check("full_held", 64'(ld_ready), 64'd0);
    alu_valid = 0;
    tick();
    wb_expect("full_w10", 1, 5'd10, 32'h100);
    tick();
    wb_expect("full_w11", 1, 5'd11, 32'h101);
    ld_valid = 0;
    tick();
    wb_expect("full_w12", 1, 5'd12, 32'h102);
    check("full_empty", 64'(busy), 64'd0);

    // hazard
    alu_valid = 1; alu_rd = 5'd2; alu_data = 32'h2;
    ld_valid = 1; ld_rd = 5'd7; ld_data = 32'h77; rs1 = 5'd7; rs2 = 5'd0;
    #1 check("haz_enq_invisible", 64'(hazard), 64'd0);
    tick();
    check("haz_rs1", 64'(hazard), 64'd1);
    rs1 = 5'd0; ld_rd = 5'd0; ld_data = 32'h5;
    #1 check("haz_x0", 64'(hazard), 64'd0);
    tick();
    ld_valid = 0; alu_valid = 0; rs2 = 5'd7;
    #1 check("haz_deq_counts", 64'(hazard), 64'd1);
    tick();
    wb_expect("haz_w7", 1, 5'd7, 32'h77);
    check("haz_clear", 64'(hazard), 64'd0);
    tick();
    check("ld_x0_no_write", 64'(wb_en), 64'd0);
    rs2 = 5'd0;

    // x0 ALU result defers to the queued load
    alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h44;
    ld_valid = 1; ld_rd = 5'd3; ld_data = 32'h33;
    tick();
    ld_valid = 0; alu_rd = 5'd0; alu_data = 32'h99;
    tick();
    wb_expect("x0_alu", 1, 5'd3, 32'h33);
    alu_valid = 0; ld_valid = 1; ld_rd = 5'd0; ld_data = 32'hDEAD;
    tick();
    ld_valid = 0;
    check("x0_ld_busy", 64'(busy), 64'd0);
    tick();
    check("x0_ld_no_write", 64'(wb_en), 64'd0);

    // reset while loads are queued
    alu_valid = 1; alu_rd = 5'd8; alu_data = 32'h88;
    ld_valid = 1; ld_rd = 5'd20; ld_data = 32'h200;
    tick();
    ld_rd = 5'd21; ld_data = 32'h201;
    tick();
    ld_valid = 0;
    check("mid_busy", 64'(busy), 64'd1);
    rst_n = 0; alu_valid = 0; rs1 = 5'd20;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_hazard", 64'(hazard), 64'd0);
    check("mid_rst_ready", 64'(ld_ready), 64'd0);
    tick();
    check("mid_wb0", 64'(wb_en), 64'd0);
    rst_n = 1;
    tick();
    check("mid_wb1", 64'(wb_en), 64'd0);
    check("mid_busy_after", 64'(busy), 64'd0);
    tick();
    check("mid_wb2", 64'(wb_en), 64'd0);

    // random traffic, checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 60) != 0);
      alu_valid = ($urandom_range(0, 2) == 0);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 1) == 1);
      ld_rd     = 5'($urandom_range(0, 7));
      ld_data   = $urandom;
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      tick();
    end

    alu_valid = 0; ld_valid = 0; rst_n = 1;
    repeat (4) tick();
    #5;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
